// File: rtl/phi_copy_sequencer_pkg.sv
// Shared types and defaults for the phi copy sequencer: FSM state
// encoding, the copy-entry record and the default ID width/scratch ID.
package phi_copy_sequencer_pkg;

    localparam int unsigned DEF_ID_W = 16;
    localparam logic [DEF_ID_W-1:0] DEF_TEMP_ID = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_SCAN    = 3'd1,
        ST_EMIT    = 3'd2,
        ST_SAVE    = 3'd3,
        ST_FLUSH   = 3'd4
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [DEF_ID_W-1:0] dest;
        logic [DEF_ID_W-1:0] src;
    } copy_entry_t;

endpackage

// File: rtl/phi_copy_sequencer_ready_picker.sv
// Combinational ready selection: an entry may be written once no other
// pending entry still reads its destination. Lowest index wins; the
// lowest pending entry is also reported as the cycle-breaking victim.
module copy_ready_picker #(
    parameter int unsigned N     = 8,
    parameter int unsigned ID_W  = 16,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]           pend,
    input  logic [N-1:0][ID_W-1:0] dest,
    input  logic [N-1:0][ID_W-1:0] src,
    output logic                   rdy_found,
    output logic [IDX_W-1:0]       rdy_idx,
    output logic                   pend_found,
    output logic [IDX_W-1:0]       pend_idx
);

    logic [N-1:0] blocked;
    logic [N-1:0] ready;

    // Compare matrix: entry i is blocked while any other pending entry reads dest[i]
    always_comb begin
        blocked = '0;
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                if (i != j && pend[j] && src[j] == dest[i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        ready = pend & ~blocked;
    end

    // Priority encoders: scanning downwards leaves the lowest set index
    always_comb begin
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        pend_found = 1'b0;
        pend_idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (ready[i]) begin
                rdy_found = 1'b1;
                rdy_idx   = IDX_W'(i);
            end
            if (pend[i]) begin
                pend_found = 1'b1;
                pend_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/phi_copy_sequencer.sv
// Turns a batch of parallel phi copies (dest <- src) into a sequence of
// moves that never clobbers a value still needed, breaking copy cycles
// through a scratch ID.
module phi_copy_sequencer
    import phi_copy_sequencer_pkg::*;
#(
    parameter int unsigned     ID_W       = DEF_ID_W,
    parameter int unsigned     MAX_COPIES = 8,
    parameter logic [ID_W-1:0] TEMP_ID    = ID_W'(DEF_TEMP_ID)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_dest,
    input  logic [ID_W-1:0] in_src,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_dest,
    output logic [ID_W-1:0] out_src,
    output logic            out_last,
    output logic            out_nop,
    output logic            err_overflow,
    output logic            err_dup
);

    localparam int unsigned IDX_W = (MAX_COPIES > 1) ? $clog2(MAX_COPIES) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_COPIES + 1);

    state_t                          state, state_nxt;
    logic [MAX_COPIES-1:0]           ent_vld;
    logic [MAX_COPIES-1:0][ID_W-1:0] ent_dest;
    logic [MAX_COPIES-1:0][ID_W-1:0] ent_src;
    logic [CNT_W-1:0]                fill_cnt, pend_cnt, pend_after;
    logic                            first_pair;
    logic [IDX_W-1:0]                sel_idx;

    logic             rdy_found, pend_found;
    logic [IDX_W-1:0] rdy_idx, pend_idx, dup_idx;
    logic             accept, out_fire, last_pend;
    logic             self_copy, dup_hit, full, add_new, add_dup, add_ovf;

    logic             out_valid_nxt, out_last_nxt, out_nop_nxt;
    logic [ID_W-1:0]  out_dest_nxt, out_src_nxt;

    assign in_ready  = (state == ST_COLLECT);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_pend = (pend_cnt == CNT_W'(1));

    copy_ready_picker #(
        .N     (MAX_COPIES),
        .ID_W  (ID_W),
        .IDX_W (IDX_W)
    ) u_picker (
        .pend       (ent_vld),
        .dest       (ent_dest),
        .src        (ent_src),
        .rdy_found  (rdy_found),
        .rdy_idx    (rdy_idx),
        .pend_found (pend_found),
        .pend_idx   (pend_idx)
    );

    // Classify the incoming pair: self copy, duplicate destination, overflow or new entry
    always_comb begin
        dup_hit = 1'b0;
        dup_idx = '0;
        for (int i = 0; i < int'(MAX_COPIES); i++) begin
            if (ent_vld[i] && ent_dest[i] == in_dest) begin
                dup_hit = 1'b1;
                dup_idx = IDX_W'(i);
            end
        end
        self_copy  = (in_dest == in_src);
        full       = (fill_cnt == CNT_W'(MAX_COPIES));
        add_new    = accept && !self_copy && !dup_hit && !full;
        add_dup    = accept && !self_copy && dup_hit;
        add_ovf    = accept && !self_copy && !dup_hit && full;
        pend_after = pend_cnt + CNT_W'(add_new);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_COLLECT;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: if (accept && in_last)
                            state_nxt = (pend_after == '0) ? ST_FLUSH : ST_SCAN;
            ST_SCAN:    if (rdy_found)       state_nxt = ST_EMIT;
                        else if (pend_found) state_nxt = ST_SAVE;
                        else                 state_nxt = ST_COLLECT;
            ST_EMIT:    if (out_fire) state_nxt = last_pend ? ST_COLLECT : ST_SCAN;
            ST_SAVE:    if (out_fire) state_nxt = ST_SCAN;
            ST_FLUSH:   if (out_fire) state_nxt = ST_COLLECT;
            default:    state_nxt = ST_COLLECT;
        endcase
    end

    // Output logic: next value of the registered move port; holds unless loading or retiring
    always_comb begin
        out_valid_nxt = out_valid;
        out_dest_nxt  = out_dest;
        out_src_nxt   = out_src;
        out_last_nxt  = out_last;
        out_nop_nxt   = out_nop;
        case (state)
            ST_COLLECT: if (accept && in_last && pend_after == '0) begin
                out_valid_nxt = 1'b1;
                out_dest_nxt  = '0;
                out_src_nxt   = '0;
                out_last_nxt  = 1'b1;
                out_nop_nxt   = 1'b1;
            end
            ST_SCAN: if (rdy_found) begin
                out_valid_nxt = 1'b1;
                out_dest_nxt  = ent_dest[rdy_idx];
                out_src_nxt   = ent_src[rdy_idx];
                out_last_nxt  = last_pend;
                out_nop_nxt   = 1'b0;
            end else if (pend_found) begin
                // Park the victim's current value in the scratch ID
                out_valid_nxt = 1'b1;
                out_dest_nxt  = TEMP_ID;
                out_src_nxt   = ent_dest[pend_idx];
                out_last_nxt  = 1'b0;
                out_nop_nxt   = 1'b0;
            end
            ST_EMIT, ST_SAVE, ST_FLUSH: if (out_fire) begin
                out_valid_nxt = 1'b0;
                out_dest_nxt  = '0;
                out_src_nxt   = '0;
                out_last_nxt  = 1'b0;
                out_nop_nxt   = 1'b0;
            end
            default: ;
        endcase
    end

    // Move port registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_dest  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
            out_nop   <= 1'b0;
        end else begin
            out_valid <= out_valid_nxt;
            out_dest  <= out_dest_nxt;
            out_src   <= out_src_nxt;
            out_last  <= out_last_nxt;
            out_nop   <= out_nop_nxt;
        end
    end

    // Copy table, occupancy counters and sticky per-batch error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld      <= '0;
            ent_dest     <= '0;
            ent_src      <= '0;
            fill_cnt     <= '0;
            pend_cnt     <= '0;
            first_pair   <= 1'b1;
            sel_idx      <= '0;
            err_overflow <= 1'b0;
            err_dup      <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: if (accept) begin
                    // Errors of the previous batch stay visible until this batch starts
                    first_pair   <= in_last;
                    err_dup      <= (err_dup & ~first_pair) | add_dup;
                    err_overflow <= (err_overflow & ~first_pair) | add_ovf;
                    if (add_new) begin
                        ent_vld[IDX_W'(fill_cnt)]  <= 1'b1;
                        ent_dest[IDX_W'(fill_cnt)] <= in_dest;
                        ent_src[IDX_W'(fill_cnt)]  <= in_src;
                        fill_cnt <= fill_cnt + CNT_W'(1);
                        pend_cnt <= pend_cnt + CNT_W'(1);
                    end
                    if (add_dup) ent_src[dup_idx] <= in_src;
                end
                ST_SCAN: sel_idx <= rdy_idx;
                ST_EMIT: if (out_fire) begin
                    ent_vld[sel_idx] <= 1'b0;
                    pend_cnt         <= pend_cnt - CNT_W'(1);
                    if (last_pend) fill_cnt <= '0;
                end
                ST_SAVE: if (out_fire) begin
                    for (int i = 0; i < int'(MAX_COPIES); i++) begin
                        if (ent_vld[i] && ent_src[i] == out_src) ent_src[i] <= TEMP_ID;
                    end
                end
                ST_FLUSH: if (out_fire) fill_cnt <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_phi_copy_sequencer.sv
// Bench for phi_copy_sequencer: directed scenarios with literal expected
// move lists, then random batches checked against a queue-based reference
// model and against parallel-copy semantics on a small register file.
module tb_phi_copy_sequencer;
    import phi_copy_sequencer_pkg::*;

    localparam int MAXC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [15:0] in_dest, in_src;
    logic        out_valid, out_ready, out_last, out_nop;
    logic [15:0] out_dest, out_src;
    logic        err_overflow, err_dup;

    always #5 clk = ~clk;

    phi_copy_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dest      (in_dest),
        .in_src       (in_src),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_dest     (out_dest),
        .out_src      (out_src),
        .out_last     (out_last),
        .out_nop      (out_nop),
        .err_overflow (err_overflow),
        .err_dup      (err_dup)
    );

    typedef struct {
        logic [15:0] d;
        logic [15:0] s;
        bit          last;
        bit          nop;
    } move_t;

    copy_entry_t batch_q[$];
    move_t       exp_q[$];
    move_t       got_q[$];
    bit          exp_ovf, exp_dup;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input move_t m);
        return {30'b0, m.nop, m.last, m.d, m.s};
    endfunction

    task automatic add_pair(input logic [15:0] d, input logic [15:0] s);
        batch_q.push_back('{1'b1, d, s});
    endtask

    task automatic add_exp(input logic [15:0] d, input logic [15:0] s, input bit last, input bit nop);
        exp_q.push_back('{d, s, last, nop});
    endtask

    // Reference: apply the batch rules to a queue of pending copies, then
    // repeatedly emit the first safe copy or park the first victim in FFFF.
    task automatic model();
        copy_entry_t ent[$];
        bit          hit, blk;
        int          pick;
        logic [15:0] t;
        exp_q.delete();
        exp_ovf = 0;
        exp_dup = 0;
        foreach (batch_q[k]) begin
            if (batch_q[k].dest != batch_q[k].src) begin
                hit = 0;
                foreach (ent[i]) if (ent[i].dest == batch_q[k].dest) begin
                    ent[i].src = batch_q[k].src;
                    hit = 1;
                end
                if (hit) exp_dup = 1;
                else if (ent.size() >= MAXC) exp_ovf = 1;
                else ent.push_back('{1'b1, batch_q[k].dest, batch_q[k].src});
            end
        end
        while (ent.size() > 0) begin
            pick = -1;
            for (int i = 0; i < ent.size() && pick < 0; i++) begin
                blk = 0;
                for (int j = 0; j < ent.size(); j++)
                    if (j != i && ent[j].src == ent[i].dest) blk = 1;
                if (!blk) pick = i;
            end
            if (pick >= 0) begin
                add_exp(ent[pick].dest, ent[pick].src, ent.size() == 1, 1'b0);
                ent.delete(pick);
            end else begin
                t = ent[0].dest;
                add_exp(16'hFFFF, t, 1'b0, 1'b0);
                foreach (ent[i]) if (ent[i].src == t) ent[i].src = 16'hFFFF;
            end
        end
        if (exp_q.size() == 0) add_exp(16'h0, 16'h0, 1'b1, 1'b1);
    endtask

    task automatic send_batch();
        foreach (batch_q[k]) begin
            in_valid = 1'b1;
            in_dest  = batch_q[k].dest;
            in_src   = batch_q[k].src;
            in_last  = (k == batch_q.size() - 1);
            chk("in_ready", in_ready, 1);
            @(posedge clk); #1;
            if (k == 0) chk("err_clear_on_first", {err_overflow, err_dup}, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_dest  = '0;
        in_src   = '0;
    endtask

    // Drain moves until out_last; every wait is bounded.
    task automatic collect(input int st_lo, input int st_hi, input int first_lat);
        int    waited, stall;
        move_t m;
        got_q.delete();
        while (got_q.size() < 24) begin
            waited = 0;
            while (!out_valid && waited < 20) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!out_valid) begin
                chk("timeout", 0, 1);
                return;
            end
            if (got_q.size() == 0) chk("latency", waited, first_lat);
            m = '{out_dest, out_src, out_last, out_nop};
            stall = $urandom_range(st_hi, st_lo);
            for (int k = 0; k < stall; k++) begin
                @(posedge clk); #1;
                chk("hold", {out_valid, pk(m)}, {1'b1, pk(m)});
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            got_q.push_back(m);
            if (m.last) return;
        end
    endtask

    task automatic compare(input string name);
        chk({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_move%0d", name, i), pk(got_q[i]), pk(exp_q[i]));
        chk({name, "_errs"}, {err_overflow, err_dup}, {exp_ovf, exp_dup});
    endtask

    task automatic run(input string name, input int st_lo, input int st_hi);
        send_batch();
        collect(st_lo, st_hi, exp_q[0].nop ? 0 : 1);
        compare(name);
    endtask

    function automatic int ix(input logic [15:0] v);
        return (v > 16'd15) ? 16 : int'(v);
    endfunction

    // The emitted moves, applied in order, must realise the parallel copy.
    task automatic check_parallel();
        int rf[17];
        int ev[17];
        bit has[17];
        for (int k = 0; k < 17; k++) begin
            rf[k] = 100 + k;
            ev[k] = 0;
            has[k] = 0;
        end
        foreach (batch_q[k]) if (batch_q[k].dest != batch_q[k].src) begin
            ev[ix(batch_q[k].dest)]  = 100 + ix(batch_q[k].src);
            has[ix(batch_q[k].dest)] = 1;
        end
        foreach (got_q[k]) if (!got_q[k].nop) rf[ix(got_q[k].d)] = rf[ix(got_q[k].s)];
        for (int k = 0; k < 16; k++)
            if (has[k]) chk($sformatf("parallel_r%0d", k), rf[k], ev[k]);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_dest   = '0;
        in_src    = '0;
        out_ready = 1'b0;
        #1;
        chk("reset_state", {in_ready, out_valid, out_last, out_nop, out_dest, out_src,
                            err_overflow, err_dup}, {1'b1, 37'b0});
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Chain: 3<-2 must go before 2<-1 overwrites 2
        batch_q.delete(); exp_q.delete();
        add_pair(2, 1); add_pair(3, 2);
        add_exp(3, 2, 0, 0); add_exp(2, 1, 1, 0);
        exp_ovf = 0; exp_dup = 0;
        run("chain", 0, 0);

        // Swap: needs the scratch ID
        batch_q.delete(); exp_q.delete();
        add_pair(1, 2); add_pair(2, 1);
        add_exp(16'hFFFF, 1, 0, 0); add_exp(1, 2, 0, 0); add_exp(2, 16'hFFFF, 1, 0);
        run("swap", 0, 0);

        // Only a self copy: one NOP beat
        batch_q.delete(); exp_q.delete();
        add_pair(5, 5);
        add_exp(0, 0, 1, 1);
        run("nop", 0, 0);

        // Nine independent copies: ninth dropped, overflow flagged
        batch_q.delete(); exp_q.delete();
        for (int i = 1; i <= 9; i++) add_pair(16'(i), 16'(20 + i));
        for (int i = 1; i <= 8; i++) add_exp(16'(i), 16'(20 + i), i == 8, 0);
        exp_ovf = 1;
        run("overflow", 0, 0);
        repeat (3) @(posedge clk);
        #1 chk("overflow_sticky", err_overflow, 1);

        // Swap with three stall cycles on every move
        batch_q.delete(); exp_q.delete();
        add_pair(1, 2); add_pair(2, 1);
        add_exp(16'hFFFF, 1, 0, 0); add_exp(1, 2, 0, 0); add_exp(2, 16'hFFFF, 1, 0);
        exp_ovf = 0;
        run("swap_stall", 3, 3);

        // Duplicate destination: last source wins
        batch_q.delete(); exp_q.delete();
        add_pair(4, 1); add_pair(4, 3);
        add_exp(4, 3, 1, 0);
        exp_dup = 1;
        run("dup", 0, 0);
        exp_dup = 0;

        // Reset while the second move of a swap is presented
        batch_q.delete();
        add_pair(1, 2); add_pair(2, 1);
        send_batch();
        @(posedge clk); #1;
        chk("rst_first_valid", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #2;
        chk("rst_second_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_async", {in_ready, out_valid, out_last, out_nop, out_dest, out_src,
                          err_overflow, err_dup}, {1'b1, 37'b0});
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rst_no_leftover", out_valid, 0);
        end
        batch_q.delete(); exp_q.delete();
        add_pair(7, 6);
        add_exp(7, 6, 1, 0);
        run("after_rst", 0, 0);

        // Random batches: cycles, chains, duplicates, self copies, overflow
        for (int b = 0; b < 40; b++) begin
            int n;
            logic [15:0] d, s;
            batch_q.delete();
            n = $urandom_range(10, 1);
            for (int k = 0; k < n; k++) begin
                d = 16'($urandom_range(11, 0));
                s = ($urandom_range(7, 0) == 0) ? d : 16'($urandom_range(11, 0));
                add_pair(d, s);
            end
            model();
            run($sformatf("rand%0d", b), 0, 2);
            if (!exp_ovf) check_parallel();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phi_copy_sequencer.md
PHI_COPY_SEQUENCER -- requirements
Module: phi_copy_sequencer

Interface
REQ-001 SHALL have parameter ID_W, default 16, width of value IDs.
REQ-002 SHALL have parameter MAX_COPIES, default 8, pair-buffer depth per batch.
REQ-003 SHALL have parameter TEMP_ID, default 16'hFFFF, scratch value ID used to break cycles.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid/in_ready  in/out  1/1  input copy-pair handshake.
REQ-007 in_dest, in_src  in  ID_W each  phi copy "dest <- src" from phi elimination.
REQ-008 in_last  in  1  final pair of the batch for one predecessor edge.
REQ-009 out_valid/out_ready  out/in  1/1  output move handshake.
REQ-010 out_dest, out_src  out  ID_W each  sequential move.
REQ-011 out_last, out_nop  out  1/1  final move of batch; batch produced no moves.
REQ-012 err_overflow, err_dup  out  1/1  sticky per batch; cleared when the next batch's first pair is accepted.

Function
REQ-013 SHALL implement FSM COLLECT, SCAN, EMIT, SAVE, FLUSH; in_ready=1 only in COLLECT.
REQ-014 COLLECT: each accepted pair with dest!=src SHALL occupy the next free entry as pending; dest==src pairs SHALL be dropped.
REQ-015 Pair whose dest equals a pending entry's dest SHALL overwrite that entry's src and set err_dup.
REQ-016 Pairs beyond MAX_COPIES entries SHALL be dropped and set err_overflow.
REQ-017 Accepting in_last SHALL move to SCAN next cycle; zero pending entries SHALL go to FLUSH instead.
REQ-018 SCAN (one cycle): entry "ready" = pending and its dest equals no other pending entry's src; lowest-index ready entry -> EMIT; none ready -> SAVE.
REQ-019 EMIT: out_dest/out_src = entry dest/src; on handshake entry cleared; last pending -> out_last=1, then COLLECT; else SCAN.
REQ-020 SAVE: with c = lowest-index pending entry, SHALL present move TEMP_ID <- c.dest; on handshake every pending src equal to c.dest SHALL become TEMP_ID; then SCAN.
REQ-021 FLUSH: out_valid=1, out_nop=1, out_last=1, dest/src=0; on handshake -> COLLECT.
REQ-022 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-023 out_valid SHALL be registered; first move valid 2 cycles after in_last accepted (SCAN+EMIT/SAVE).
REQ-024 Batch of N acyclic pending entries SHALL emit exactly N moves; each cycle adds exactly one SAVE move.

Reset
REQ-025 rst SHALL immediately force COLLECT, clear all entries, and drive in_ready=1, out_valid=0, out_last=0, out_nop=0, out_dest=0, out_src=0, err_overflow=0, err_dup=0.
REQ-026 rst mid-batch or mid-emit SHALL discard the batch; no move of it SHALL appear after reset release.

Structure
REQ-027 Shared package SHALL hold state enum, copy-entry struct (valid, dest, src), and default ID_W/TEMP_ID constants.
REQ-028 Ready-selection (pending vector, dest-vs-src compare matrix, priority encoder) SHALL be sub-module copy_ready_picker, purely combinational.

Verification
REQ-029 Chain (2<-1),(3<-2, last) -> moves 3<-2, then 2<-1 out_last=1; no TEMP_ID.
REQ-030 Swap (1<-2),(2<-1, last) -> FFFF<-1, 1<-2, 2<-FFFF out_last=1.
REQ-031 Only (5<-5, last) -> one beat out_nop=1, out_last=1.
REQ-032 Nine distinct acyclic pairs, MAX_COPIES=8 -> eight moves, err_overflow=1 until next batch's first accept.
REQ-033 Swap batch, out_ready low 3 cycles on each move -> outputs stable, same 3-move sequence.
REQ-034 rst pulse after first move of swap -> out_valid=0 asynchronously; new batch (7<-6, last) -> single move 7<-6.
